demux_1to2_buf: RTL

- Reverse-direction counterpart of the datapath 2:1 select.
- Takes one 32-bit producer stream and steers each word to one of two consumers, chosen per word by a select bit.
- Each consumer lane has its own small FIFO, so a stalled consumer never loses data. The other lane keeps flowing.
- Used where a single result bus fans out to two downstream stages.

---
 rtl/demux_pkg.sv | 11 +
 rtl/demux_1to2_buf_lane_fifo.sv | 54 +++++
 rtl/demux_1to2_buf.sv | 89 ++++++++
 3 files changed

// File: rtl/demux_pkg.sv
// Shared constants for the 1:2 buffered demux: default sizes, lane indices, stats width.
package demux_pkg;
    localparam int DEMUX_WIDTH = 32;
    localparam int DEMUX_DEPTH = 2;

    localparam logic LANE0 = 1'b0;
    localparam logic LANE1 = 1'b1;

    localparam int              STAT_W   = 16;
    localparam logic [STAT_W-1:0] STAT_MAX = {STAT_W{1'b1}};
endpackage

// File: rtl/demux_1to2_buf_lane_fifo.sv
// Per-lane synchronous FIFO. The head word is read straight from storage, and full
// depends only on registered state, so a full lane never accepts on the cycle it pops.
module lane_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic             valid,
    output logic             full,
    output logic [WIDTH-1:0] rdata
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
    localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [AW-1:0]               wr_ptr;
    logic [AW-1:0]               rd_ptr;
    logic [AW:0]                 count;
    logic                        do_push;
    logic                        do_pop;

    assign valid   = (count != '0);
    assign full    = (count == CNT_MAX);
    assign rdata   = mem[rd_ptr];
    assign do_push = push & ~full;
    assign do_pop  = pop & valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + PTR_ONE;
            end
            if (do_pop)
                rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/demux_1to2_buf.sv
// One producer stream steered per word to two buffered consumer lanes.
// Optional pop counters per lane when DEMUX_STATS_EN is defined.
module demux_1to2_buf
    import demux_pkg::*;
#(
    parameter int WIDTH = DEMUX_WIDTH,
    parameter int DEPTH = DEMUX_DEPTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic               in_sel,
    output logic               out0_valid,
    input  logic               out0_ready,
    output logic [WIDTH-1:0]   out0_data,
    output logic               out1_valid,
    input  logic               out1_ready,
`ifdef DEMUX_STATS_EN
    output logic [STAT_W-1:0]  stat0_cnt,
    output logic [STAT_W-1:0]  stat1_cnt,
`endif
    output logic [WIDTH-1:0]   out1_data
);
    logic full0, full1;
    logic push0, push1;

    // An unknown select falls to the default arm: not ready, nothing routed.
    always_comb begin
        in_ready = 1'b0;
        push0    = 1'b0;
        push1    = 1'b0;
        case (in_sel)
            LANE0: begin
                in_ready = ~full0;
                push0    = in_valid;
            end
            LANE1: begin
                in_ready = ~full1;
                push1    = in_valid;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

    lane_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_lane0 (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push0),
        .pop   (out0_ready),
        .wdata (in_data),
        .valid (out0_valid),
        .full  (full0),
        .rdata (out0_data)
    );

    lane_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_lane1 (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push1),
        .pop   (out1_ready),
        .wdata (in_data),
        .valid (out1_valid),
        .full  (full1),
        .rdata (out1_data)
    );

`ifdef DEMUX_STATS_EN
    logic [STAT_W-1:0] stat0_q, stat1_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat0_q <= '0;
            stat1_q <= '0;
        end else begin
            if (out0_valid && out0_ready && stat0_q != STAT_MAX)
                stat0_q <= stat0_q + STAT_W'(1);
            if (out1_valid && out1_ready && stat1_q != STAT_MAX)
                stat1_q <= stat1_q + STAT_W'(1);
        end
    end

    assign stat0_cnt = stat0_q;
    assign stat1_cnt = stat1_q;
`endif
endmodule
